// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared types for the SPI transfer arbiter: FSM state encoding and slave-select codes.
// ss codes are decoded at the top level into individual trig/ch1..ch3/EEP chip selects.
package spi_xfer_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    WAIT,
    ACK,
    GAP
  } state_t;

  localparam logic [2:0] SS_TRIG = 3'd0;
  localparam logic [2:0] SS_CH1  = 3'd1;
  localparam logic [2:0] SS_CH2  = 3'd2;
  localparam logic [2:0] SS_CH3  = 3'd3;
  localparam logic [2:0] SS_EEP  = 3'd4;
  localparam logic [2:0] SS_NONE = 3'd7;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit searching upward from ptr+1 with wrap; purely combinational.
// Zero latency, no state; callers hold ptr to the last winner so it becomes lowest priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int c;

  // Walk from farthest to nearest so the nearest requester after ptr overwrites last and wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_vld    = 1'b0;
    c          = 0;
    for (int i = N; i >= 1; i--) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (req[c[IW-1:0]]) begin
        gnt_onehot             = '0;
        gnt_onehot[c[IW-1:0]]  = 1'b1;
        gnt_idx                = c[IW-1:0];
        gnt_vld                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master among NREQ requesters round-robin; gnt 1 cycle after req, wrt_spi in the WRITE state two cycles after req is seen, ack 1 cycle after spi_done.
// Requesters are backpressured by holding req until ack; the SPI side has no timeout and waits for spi_done indefinitely.
module spi_xfer_arbiter
  import spi_xfer_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_cmd,
  input  logic [3*NREQ-1:0]    req_ss,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [15:0]          rdata,
  output logic                 busy,
  output logic                 wrt_spi,
  output logic [15:0]          spi_cmd,
  output logic [2:0]           ss,
  input  logic                 spi_done,
  input  logic [15:0]          spi_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic            win_vld;
  logic [GW-1:0]   gap_cnt;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req        (req),
    .ptr        (ptr),
    .gnt_onehot (win_onehot),
    .gnt_idx    (win_idx),
    .gnt_vld    (win_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      ack     <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      wrt_spi <= 1'b0;
      spi_cmd <= '0;
      ss      <= SS_NONE;
      ptr     <= IW'(NREQ - 1);
      gap_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // spi_cmd/ss are sampled only here, so later req_cmd/req_ss changes cannot disturb a transfer.
          if (win_vld) begin
            gnt     <= win_onehot;
            spi_cmd <= req_cmd[16*win_idx +: 16];
            ss      <= req_ss[3*win_idx +: 3];
            ptr     <= win_idx;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          wrt_spi <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          wrt_spi <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (spi_done) begin
            rdata <= spi_data;
            ack   <= gnt;
            state <= ACK;
          end
        end
        ACK: begin
          ack     <= '0;
          gnt     <= '0;
          gap_cnt <= GAP_LAST;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: table of single transfers plus hand-written sequences for
// latched command/ss, dropped requests, spurious spi_done, reset mid-transfer and round-robin order.
module tb_spi_xfer_arbiter;
  import spi_xfer_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int GAP  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  req_cmd;
  logic [3*NREQ-1:0]   req_ss;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     ack;
  logic [15:0]         rdata;
  logic                busy;
  logic                wrt_spi;
  logic [15:0]         spi_cmd;
  logic [2:0]          ss;
  logic                spi_done;
  logic [15:0]         spi_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_xfer_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_cmd  (req_cmd),
    .req_ss   (req_ss),
    .gnt      (gnt),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .wrt_spi  (wrt_spi),
    .spi_cmd  (spi_cmd),
    .ss       (ss),
    .spi_done (spi_done),
    .spi_data (spi_data)
  );

  typedef struct {
    logic [3:0]  req;
    logic [63:0] cmd;
    logic [11:0] ssv;
    logic [15:0] data;
    int          who;
  } vec_t;

  typedef struct {
    int          who;
    logic [15:0] cmd;
    logic [2:0]  ssv;
    logic [15:0] data;
  } exp_t;

  vec_t vecs[7];
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wrt"}, wrt_spi, 0);
    chk({tag, "_cmd"}, spi_cmd, 0);
    chk({tag, "_ss"}, ss, 3'b111);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  // Pops the next expected transfer and plays the SPI master side of it.
  // exp_n: negedges until gnt appears (0 = unchecked); mode 1 alters req_cmd/req_ss in WAIT, mode 2 drops req in WAIT.
  task automatic run_xfer(input int exp_n, input int mode, input bit hold);
    exp_t e;
    int   n = 0;
    bit   seen = 0;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: no expected transfer queued");
      return;
    end
    e = exp_q.pop_front();
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (gnt != '0) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: no grant seen, expected gnt[%0d]", e.who);
      return;
    end
    if (exp_n != 0) chk("gnt_latency", n, exp_n);
    chk("gnt", gnt, 32'd1 << e.who);
    chk("spi_cmd", spi_cmd, e.cmd);
    chk("ss", ss, e.ssv);
    chk("wrt_setup", wrt_spi, 0);
    chk("busy", busy, 1);
    @(negedge clk); chk("wrt_pulse", wrt_spi, 1);
    @(negedge clk); chk("wrt_clear", wrt_spi, 0);
    if (mode == 1) begin
      req_cmd[16*e.who +: 16] = ~e.cmd;
      req_ss[3*e.who +: 3]    = ~e.ssv;
    end
    if (mode == 2) req[e.who] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wait_no_ack", ack, 0);
      chk("wait_cmd", spi_cmd, e.cmd);
      chk("wait_ss", ss, e.ssv);
    end
    spi_done = 1'b1;
    spi_data = e.data;
    @(negedge clk);
    spi_done = 1'b0;
    spi_data = 16'hDEAD;
    chk("ack", ack, 32'd1 << e.who);
    chk("ack_gnt", gnt, 32'd1 << e.who);
    chk("rdata", rdata, e.data);
    if (!hold) req = '0;
    @(negedge clk);
    chk("ack_once", ack, 0);
    chk("gap_gnt", gnt, 0);
    chk("rdata_held", rdata, e.data);
    chk("gap_cmd", spi_cmd, e.cmd);
    chk("gap_ss", ss, e.ssv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0010, {16'h3333, 16'h2222, 16'hA5C3, 16'h1111}, {3'd3, 3'd2, 3'd1, 3'd0}, 16'h1234, 1};
    vecs[1] = '{4'b0101, {16'h4D4D, 16'hC0DE, 16'h0101, 16'h7F00}, {3'd3, 3'd2, 3'd1, 3'd0}, 16'h55AA, 2};
    vecs[2] = '{4'b0011, {16'h0003, 16'h0002, 16'h8001, 16'h9000}, {3'd4, 3'd3, 3'd2, 3'd1}, 16'hFFFF, 0};
    vecs[3] = '{4'b1000, {16'h0300, 16'h0000, 16'h0000, 16'h0000}, {3'd4, 3'd0, 3'd0, 3'd0}, 16'h007E, 3};
    vecs[4] = '{4'b1010, {16'hAAAA, 16'hBBBB, 16'h6E6E, 16'hCCCC}, {3'd4, 3'd2, 3'd3, 3'd1}, 16'h0000, 1};
    vecs[5] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h1F2E}, {3'd0, 3'd0, 3'd0, 3'd4}, 16'hF00D, 0};
    vecs[6] = '{4'b1111, {16'h1D1D, 16'h2C2C, 16'h5A5A, 16'h3B3B}, {3'd4, 3'd3, 3'd2, 3'd1}, 16'h8421, 1};

    rst = 1'b1; req = '0; req_cmd = '0; req_ss = '0; spi_done = 1'b0; spi_data = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      wait_idle();
      req_cmd = vecs[i].cmd;
      req_ss  = vecs[i].ssv;
      exp_q.push_back('{vecs[i].who, vecs[i].cmd[16*vecs[i].who +: 16],
                        vecs[i].ssv[3*vecs[i].who +: 3], vecs[i].data});
      req = vecs[i].req;
      run_xfer(1, 0, 0);
    end

    // Command/ss latched at grant, then a stray spi_done while idle.
    wait_idle();
    req_cmd[32 +: 16] = 16'hBEEF;
    req_ss[6 +: 3]    = SS_CH3;
    exp_q.push_back('{2, 16'hBEEF, SS_CH3, 16'h1357});
    req = 4'b0100;
    run_xfer(1, 1, 0);
    wait_idle();
    chk("idle_ss_held", ss, SS_CH3);
    spi_done = 1'b1;
    spi_data = 16'hFFFF;
    @(negedge clk);
    spi_done = 1'b0;
    chk("spurious_ack", ack, 0);
    chk("spurious_busy", busy, 0);
    chk("spurious_rdata", rdata, 16'h1357);
    @(negedge clk);
    chk("spurious_gnt", gnt, 0);

    // Requester withdraws during WAIT: transfer still acked, nothing restarts.
    req_cmd[0 +: 16] = 16'h0C0C;
    req_ss[0 +: 3]   = SS_TRIG;
    exp_q.push_back('{0, 16'h0C0C, SS_TRIG, 16'h2468});
    req = 4'b0001;
    run_xfer(1, 2, 0);
    repeat (8) begin
      @(negedge clk);
      chk("no_restart_gnt", gnt, 0);
      chk("no_restart_wrt", wrt_spi, 0);
    end

    // Reset asserted while waiting for spi_done.
    req = 4'b0001;
    @(negedge clk); chk("pre_rst_gnt", gnt, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    req = '0;
    rst = 1'b0;

    // All four requesting continuously: 0,1,2,3,0 with GAP+1 cycles of gnt low between grants.
    req_cmd = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    req_ss  = {SS_CH3, SS_CH2, SS_CH1, SS_TRIG};
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back('{k % 4, 16'hD000 + 16'(k % 4), 3'(k % 4), 16'hE000 + 16'(k)});
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_xfer((k == 0) ? 1 : GAP + 1, 0, k != 4);
    end
    wait_idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
